diffeq_param_sequencer: RTL

- Upstream stage for the 4-bit differential-equation datapath (load-select inputs, start, y, valid).
- Accepts one packed 4-operand job from a host via valid/ready and serialises the operands into the datapath's slot-select load port over 4 cycles.
- Holds start high until the datapath reports valid, then captures y and presents it to the host via valid/ready.

---
 rtl/diffeq_param_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/diffeq_param_sequencer.sv
// Host-side sequencer for the 4-bit differential-equation datapath: takes a packed
// 4-operand job, serialises it onto the slot-select load port, runs the datapath, returns y.
// Optional build macro SEQ_TIMEOUT_EN adds a RUN watchdog that aborts with out_err.
//
// state | meaning
// IDLE  | waiting for a host job, in_ready high
// LOAD  | presenting slots 0..3 on ld_sel/ld_data, one per cycle
// RUN   | start held high until the datapath reports y_valid
// HOLD  | result presented to the host until out_ready
module diffeq_param_sequencer #(
    parameter int DW      = 4,
    parameter int TIMEOUT = 2047
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*DW-1:0] in_data,
    output logic [DW-1:0]   ld_data,
    output logic [1:0]      ld_sel,
    output logic            start,
    input  logic [DW-1:0]   y_in,
    input  logic            y_valid,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_err,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    state_t          state, state_nxt;
    logic [4*DW-1:0] shadow, shadow_nxt;
    logic [1:0]      ld_sel_nxt, sel_inc;
    logic [DW-1:0]   ld_data_nxt, out_data_nxt;
    logic            start_nxt, out_valid_nxt;

`ifdef SEQ_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 11) ? $clog2(TIMEOUT + 1) : 11;
    logic [CW-1:0] run_cnt, run_cnt_nxt;
    logic          out_err_nxt;
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        shadow_nxt    = shadow;
        ld_sel_nxt    = ld_sel;
        ld_data_nxt   = ld_data;
        start_nxt     = start;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        sel_inc       = ld_sel + 2'd1;
`ifdef SEQ_TIMEOUT_EN
        run_cnt_nxt   = run_cnt;
        out_err_nxt   = out_err;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    shadow_nxt  = in_data;
                    ld_sel_nxt  = 2'd0;
                    ld_data_nxt = in_data[DW-1:0];
                    state_nxt   = LOAD;
                end
            end
            LOAD: begin
                // slot 3 stays on the load port after the last load
                if (ld_sel == 2'd3) begin
                    start_nxt = 1'b1;
                    state_nxt = RUN;
`ifdef SEQ_TIMEOUT_EN
                    run_cnt_nxt = '0;
`endif
                end else begin
                    ld_sel_nxt  = sel_inc;
                    ld_data_nxt = shadow[sel_inc*DW +: DW];
                end
            end
            RUN: begin
                if (y_valid) begin
                    out_data_nxt  = y_in;
                    start_nxt     = 1'b0;
                    out_valid_nxt = 1'b1;
                    state_nxt     = HOLD;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (run_cnt == CW'(TIMEOUT - 1)) begin
                    out_data_nxt  = '0;
                    start_nxt     = 1'b0;
                    out_valid_nxt = 1'b1;
                    out_err_nxt   = 1'b1;
                    state_nxt     = HOLD;
                end else begin
                    run_cnt_nxt = run_cnt + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
`ifdef SEQ_TIMEOUT_EN
                    out_err_nxt   = 1'b0;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            ld_sel    <= '0;
            ld_data   <= '0;
            start     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            shadow    <= shadow_nxt;
            ld_sel    <= ld_sel_nxt;
            ld_data   <= ld_data_nxt;
            start     <= start_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
            out_err <= 1'b0;
        end else begin
            run_cnt <= run_cnt_nxt;
            out_err <= out_err_nxt;
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule
